// File: rtl/riscv_definitions.sv
// Shared definitions for the data-memory bridge: FSM state encoding,
// access-size masks and a byte-lane mask expander.
package riscv_definitions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BYTE = 4'b0001;
  localparam logic [3:0] HALF = 4'b0011;
  localparam logic [3:0] WORD = 4'b1111;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Word-aligned system bus between the data-memory bridge (master) and memory (slave).
interface dmem_bridge_if;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack;
  logic        i_bus_err;
  logic [31:0] i_bus_rdata;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    input  i_bus_ack, i_bus_err, i_bus_rdata
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    output i_bus_ack, i_bus_err, i_bus_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: shifts store data/byte enables onto bus lanes and
// brings load data back right-aligned, masked to the access size.
module dmem_lane_align
  import riscv_definitions::*;
(
  input  logic [1:0]  ofs,
  input  logic [3:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_al
);

  // Lanes shifted past byte 3 fall off the top; no wrap into the next word.
  assign be       = size << ofs;
  assign wdata_sh = wdata << {ofs, 3'b000};
  assign rdata_al = (rdata >> {ofs, 3'b000}) & lane_mask(size);

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to system-bus bridge: one outstanding access, stall while busy,
// timeout abort. Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_bridge
  import riscv_definitions::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   i_data_addr,
  input  logic [31:0]   i_data_wr,
  input  logic [3:0]    i_data_rd_en_ctrl,
  input  logic          i_data_rd_en,
  input  logic          i_data_wr_en,
  output logic [31:0]   o_data_rd,
  output logic          o_stall,
  output logic          o_err,
  dmem_bridge_if.master bus
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, wdata_q, data_rd_q;
  logic [3:0]  size_q;
  logic        we_q, err_q;
  logic [15:0] cnt_q, cnt_inc;
  logic        req, misalign, start, done_ok, abort, abort_ld, in_wait;
  logic [3:0]  be_al;
  logic [31:0] wdata_al, rdata_al;

  assign req     = i_data_rd_en | i_data_wr_en;
  assign in_wait = (state_q == WAIT);
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((i_data_rd_en_ctrl == HALF) && i_data_addr[0]) ||
               ((i_data_rd_en_ctrl == WORD) && (i_data_addr[1:0] != 2'b00));
`endif
  end

  dmem_lane_align u_align (
    .ofs      (addr_q[1:0]),
    .size     (size_q),
    .wdata    (wdata_q),
    .rdata    (bus.i_bus_rdata),
    .be       (be_al),
    .wdata_sh (wdata_al),
    .rdata_al (rdata_al)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Error beats ack; ack beats a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    done_ok  = 1'b0;
    abort    = 1'b0;
    abort_ld = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          start = 1'b1;
          if (misalign) begin
            abort    = 1'b1;
            abort_ld = !i_data_wr_en;
            state_d  = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.i_bus_err || (!bus.i_bus_ack && (cnt_inc == TMO))) begin
          abort    = 1'b1;
          abort_ld = !we_q;
          state_d  = DONE;
        end else if (bus.i_bus_ack) begin
          done_ok = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      data_rd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= abort;
      if (start) begin
        addr_q  <= i_data_addr;
        wdata_q <= i_data_wr;
        size_q  <= i_data_rd_en_ctrl;
        we_q    <= i_data_wr_en;
        cnt_q   <= '0;
      end else if (in_wait) begin
        cnt_q <= cnt_inc;
      end
      if (done_ok && !we_q) data_rd_q <= rdata_al;
      else if (abort_ld)    data_rd_q <= '0;
    end
  end

  // Bus is driven only while waiting, so it reads all-zero in IDLE/DONE/reset.
  assign bus.o_bus_req   = in_wait;
  assign bus.o_bus_we    = in_wait & we_q;
  assign bus.o_bus_addr  = in_wait ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.o_bus_be    = in_wait ? be_al : 4'd0;
  assign bus.o_bus_wdata = in_wait ? wdata_al : 32'd0;

  assign o_stall   = !rst && (((state_q == IDLE) && req) || in_wait);
  assign o_err     = err_q;
  assign o_data_rd = data_rd_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: random loads/stores against a transaction-level model.
module tb_dmem_bridge;
  import riscv_definitions::*;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          k;      // WAIT cycle (1-based) carrying the response; 0 = never
    logic        berr;
    logic [31:0] rdata;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          stall;
  } res_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data_addr, i_data_wr, o_data_rd;
  logic [3:0]  i_data_rd_en_ctrl;
  logic        i_data_rd_en, i_data_wr_en, o_stall, o_err;
  logic        force_ack = 1'b0;

  bus_exp_t bus_q[$];
  res_exp_t exp_q[$];
  logic [31:0] model_rd = 32'd0;
  int n_vec = 0;
  int n_fail = 0;

  dmem_bridge_if bus ();

  dmem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_data_addr       (i_data_addr),
    .i_data_wr         (i_data_wr),
    .i_data_rd_en_ctrl (i_data_rd_en_ctrl),
    .i_data_rd_en      (i_data_rd_en),
    .i_data_wr_en      (i_data_wr_en),
    .o_data_rd         (o_data_rd),
    .o_stall           (o_stall),
    .o_err             (o_err),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] size);
    if (size == BYTE) return 1;
    if (size == HALF) return 2;
    return 4;
  endfunction

  task automatic wait_done();
    bit seen = 0;
    for (int cyc = 0; ; cyc++) begin
      @(negedge clk);
      if (o_stall) seen = 1;
      else if (seen) break;
      if (cyc > 40) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] size,
                       input logic [31:0] wdata, input int k, input bit berr, input logic [31:0] rdata);
    int n, ofs;
    bit mis, fail;
    bus_exp_t b;
    res_exp_t r;
    n   = size_bytes(size);
    ofs = int'(addr[1:0]);
    mis = 0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (ofs % n) != 0;
`endif
    if (mis) begin
      fail    = 1;
      r.stall = 1;
    end else begin
      b.addr  = addr & ~32'd3;
      b.be    = 4'((32'd1 << n) - 32'd1 << ofs);
      b.wdata = wdata << (8 * ofs);
      b.we    = wr;
      b.k     = k;
      b.berr  = berr;
      b.rdata = rdata;
      bus_q.push_back(b);
      if (k >= 1 && k <= TMO) begin
        fail    = berr;
        r.stall = 1 + k;
      end else begin
        fail    = 1;
        r.stall = 1 + TMO;
      end
    end
    if (!wr) begin
      if (fail)        model_rd = 32'd0;
      else if (n == 4) model_rd = rdata >> (8 * ofs);
      else             model_rd = (rdata >> (8 * ofs)) & ((32'd1 << (8 * n)) - 32'd1);
    end
    r.err = fail;
    r.rd  = model_rd;
    exp_q.push_back(r);
    @(posedge clk); #1;
    i_data_rd_en      = rd;
    i_data_wr_en      = wr;
    i_data_addr       = addr;
    i_data_rd_en_ctrl = size;
    i_data_wr         = wdata;
    wait_done();
  endtask

  // Bus responder: checks request fields every WAIT cycle, answers per script,
  // and throws junk acks/errors whenever no request is open.
  initial begin
    bus_exp_t cur = '{default: '0};
    bit active = 0;
    int cyc = 0;
    bus.i_bus_ack = 1'b0;
    bus.i_bus_err = 1'b0;
    bus.i_bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_err   = 1'b0;
        bus.i_bus_rdata = 32'hCAFEF00D;
        active = 0;
      end else if (bus.o_bus_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
            cur = '{default: '0};
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1;
          cyc = 1;
        end else begin
          cyc++;
        end
        chk("bus_addr", bus.o_bus_addr, cur.addr);
        chk("bus_be", {28'd0, bus.o_bus_be}, {28'd0, cur.be});
        chk("bus_wdata", bus.o_bus_wdata, cur.wdata);
        chk("bus_we", {31'd0, bus.o_bus_we}, {31'd0, cur.we});
        if (cyc == cur.k) begin
          bus.i_bus_ack   = !cur.berr || ($urandom_range(0, 1) == 1);
          bus.i_bus_err   = cur.berr;
          bus.i_bus_rdata = cur.rdata;
        end else begin
          bus.i_bus_ack   = 1'b0;
          bus.i_bus_err   = 1'b0;
          bus.i_bus_rdata = $urandom;
        end
      end else begin
        active = 0;
        bus.i_bus_ack   = ($urandom_range(0, 1) == 1);
        bus.i_bus_err   = ($urandom_range(0, 3) == 0);
        bus.i_bus_rdata = $urandom;
      end
    end
  end

  // Completion monitor: a stall-high run ending marks DONE; compare against the scoreboard.
  initial begin
    res_exp_t r;
    bit prev = 0;
    int scnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0;
        scnt = 0;
      end else if (o_stall) begin
        scnt++;
        prev = 1;
        chk("err_while_stalled", {31'd0, o_err}, 32'd0);
      end else if (prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("done_err", {31'd0, o_err}, {31'd0, r.err});
          chk("done_data_rd", o_data_rd, r.rd);
          chk("stall_cycles", 32'(scnt), 32'(r.stall));
        end
        prev = 0;
        scnt = 0;
      end else begin
        chk("idle_err", {31'd0, o_err}, 32'd0);
      end
    end
  end

  initial begin
    bus_exp_t b;
    rst = 1'b1;
    i_data_addr = 32'd0;
    i_data_wr = 32'd0;
    i_data_rd_en_ctrl = WORD;
    i_data_rd_en = 1'b1;
    i_data_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_req", {31'd0, bus.o_bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus.o_bus_we}, 32'd0);
    chk("rst_be", {28'd0, bus.o_bus_be}, 32'd0);
    chk("rst_addr", bus.o_bus_addr, 32'd0);
    chk("rst_wdata", bus.o_bus_wdata, 32'd0);
    chk("rst_data_rd", o_data_rd, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    @(posedge clk); #1 i_data_rd_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Load abandoned by reset in WAIT, followed by a late ack.
    b = '{addr: 32'h40, be: 4'hF, wdata: 32'd0, we: 1'b0, k: 0, berr: 1'b0, rdata: 32'd0};
    bus_q.push_back(b);
    @(posedge clk); #1;
    i_data_addr = 32'h40;
    i_data_rd_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'd0, bus.o_bus_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    i_data_rd_en = 1'b0;
    #1;
    chk("midwait_rst_req", {31'd0, bus.o_bus_req}, 32'd0);
    chk("midwait_rst_stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_err", {31'd0, o_err}, 32'd0);
      chk("late_ack_data_rd", o_data_rd, 32'd0);
      chk("late_ack_req", {31'd0, bus.o_bus_req}, 32'd0);
    end
    @(posedge clk); #1 force_ack = 1'b0;

    // Directed cases from the requirements.
    issue(1, 0, 32'h100, WORD, 32'd0, 3, 0, 32'hDEADBEEF);
    issue(0, 1, 32'h103, BYTE, 32'h000000A5, 1, 0, 32'd0);
    issue(1, 0, 32'h202, HALF, 32'd0, 2, 0, 32'h8001FFFF);
    issue(1, 0, 32'h300, WORD, 32'd0, 99, 0, 32'h12345678);
    issue(1, 0, 32'h304, WORD, 32'd0, 1, 0, 32'h0BADF00D);
    issue(1, 0, 32'h308, BYTE, 32'd0, 2, 1, 32'hFFFFFFFF);
    issue(1, 1, 32'h30C, HALF, 32'h0000BEEF, 1, 0, 32'h11111111);
    issue(1, 0, 32'h310, WORD, 32'd0, TMO, 0, 32'hA5A5A5A5);
`ifdef DMEM_MISALIGN_CHECK_EN
    issue(1, 0, 32'h101, WORD, 32'd0, 1, 0, 32'h55555555);
`endif

    for (int i = 0; i < 160; i++) begin
      int op;
      logic [3:0] sz;
      op = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       sz = BYTE;
        1:       sz = HALF;
        default: sz = WORD;
      endcase
      issue(op != 1, op != 0, $urandom, sz, $urandom, $urandom_range(1, 6),
            $urandom_range(0, 5) == 0, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        i_data_rd_en = 1'b0;
        i_data_wr_en = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    @(posedge clk); #1;
    i_data_rd_en = 1'b0;
    i_data_wr_en = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_script_drained", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before abort (1..65535).
REQ-002 clk  input  1  system clock; single clock domain, all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_data_addr  input  32  byte address from MEM stage.
REQ-005 i_data_wr  input  32  store data from MEM stage, right-aligned.
REQ-006 i_data_rd_en_ctrl  input  4  access size mask: 0001 byte, 0011 half, 1111 word.
REQ-007 i_data_rd_en, i_data_wr_en  input  1 each  load / store request.
REQ-008 o_data_rd  output  32  load data to MEM stage, right-aligned, raw (MEM stage extends).
REQ-009 o_stall  output  1  pipeline hold; MEM stage clk_en = !o_stall.
REQ-010 o_err  output  1  one-cycle pulse: bus error or timeout.
REQ-011 o_bus_req, o_bus_we  output  1 each  bus request / write strobe.
REQ-012 o_bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 o_bus_wdata  output  32, o_bus_be  output  4  lane-shifted data and byte enables.
REQ-014 i_bus_ack, i_bus_err  input  1 each, i_bus_rdata  input  32  bus response.

Function
REQ-015 FSM states IDLE, WAIT, DONE; encoding from shared package.
REQ-016 IDLE with rd_en|wr_en: o_stall=1 combinationally same cycle; register addr, data, size, we; next WAIT.
REQ-017 rd_en and wr_en both high: SHALL be executed as a write.
REQ-018 WAIT: o_bus_req=1 and bus outputs held constant until ack, err or timeout; o_stall=1.
REQ-019 o_bus_be = size mask << addr[1:0], truncated to 4 bits; o_bus_wdata = wdata << 8*addr[1:0].
REQ-020 WAIT with i_bus_ack: load captures i_bus_rdata >> 8*addr[1:0], masked to size, into o_data_rd; next DONE.
REQ-021 i_bus_err (priority over ack in same cycle) or wait counter = TIMEOUT_CYCLES: o_err pulse, o_data_rd=0 for loads, next DONE.
REQ-022 DONE: o_stall=0, o_bus_req=0, lasts exactly one cycle, next IDLE; a request visible in DONE is not started.
REQ-023 Minimum access: request cycle 0, ack cycle 1, DONE cycle 2; stall high cycles 0-1.
REQ-024 Wait counter 16 bits, cleared on entering WAIT, saturating; no wrap.
REQ-025 o_data_rd holds last value until the next load completes; stores do not modify it.
REQ-026 i_bus_ack/i_bus_err in IDLE or DONE SHALL be ignored.

Reset
REQ-027 rst asserted: state IDLE, o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_data_rd=0, o_err=0, counter=0, immediately.
REQ-028 Reset during WAIT abandons the transaction; no o_err; a later ack is ignored per REQ-026.
REQ-029 o_stall=0 during reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 skips WAIT, no bus request, pulses o_err, o_data_rd=0 for loads, goes IDLE->DONE.
REQ-031 Macro undefined: no misalignment check; masks shifted per REQ-019, out-of-word lanes dropped.

Structure
REQ-032 riscv_definitions holds dmem_state_t and size-mask constants (BYTE, HALF, WORD).
REQ-033 Combinational sub-module dmem_lane_align performs write shift/BE generation and read shift/mask.

Verification
REQ-034 LW addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF -> o_data_rd=0xDEADBEEF, stall high 4 cycles, then DONE.
REQ-035 SB addr 0x103, wdata 0x000000A5 -> o_bus_be=1000, o_bus_wdata=0xA5000000, o_bus_addr=0x100, o_bus_we=1.
REQ-036 LH addr 0x202, rdata 0x8001FFFF -> o_data_rd=0x00008001.
REQ-037 LW, TIMEOUT_CYCLES=4, never ack -> o_err pulse after 4 WAIT cycles, o_data_rd=0, FSM back in IDLE.
REQ-038 rst pulse mid-WAIT then late ack -> o_bus_req=0 immediately, no o_err, o_data_rd unchanged at 0.
REQ-039 With DMEM_MISALIGN_CHECK_EN, LW addr 0x101 -> no o_bus_req, o_err pulse, stall high one cycle.
